// File: rtl/ctrl_pkg.sv
// Opcode map, sequencer states and execute-length lookup shared by the MiniSRC step sequencer.
package ctrl_pkg;

  localparam int OPC_W       = 5;
  localparam int FETCH_STEPS = 3;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd14;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd15;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd16;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'd17;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd18;
  localparam logic [OPC_W-1:0] OP_BR   = 5'd19;
  localparam logic [OPC_W-1:0] OP_JR   = 5'd20;
  localparam logic [OPC_W-1:0] OP_JAL  = 5'd21;
  localparam logic [OPC_W-1:0] OP_IN   = 5'd22;
  localparam logic [OPC_W-1:0] OP_OUT  = 5'd23;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'd24;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'd25;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd26;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALTED,
    S_FAULT
  } seq_state_t;

  // Number of execute steps (T3 onward); unknown opcodes behave as a one-step nop.
  function automatic logic [2:0] exec_steps(input logic [OPC_W-1:0] op);
    logic [2:0] n;
    n = 3'd1;
    case (op) inside
      OP_LD, OP_MUL, OP_DIV:                          n = 3'd4;
      [OP_ADD:OP_ORI], OP_NEG, OP_NOT,
      OP_LDI, OP_ST, OP_BR:                           n = 3'd3;
      OP_JR, OP_JAL:                                  n = 3'd2;
      OP_IN, OP_OUT, OP_MFHI, OP_MFLO, OP_NOP, OP_HALT: n = 3'd1;
      default:                                        n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic is_illegal(input logic [OPC_W-1:0] op);
    return op > OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_step_counter.sv
// Step index register with one-hot encode; advances, wraps to T0, or parks at all-zero.
module ctrl_step_counter #(
  parameter  int MAX_STEPS = 8,
  localparam int IDX_W     = $clog2(MAX_STEPS)
) (
  input  logic                 iClk,
  input  logic                 nRst,
  input  logic                 adv,
  input  logic                 wrap,
  input  logic                 park,
  input  logic                 resume,
  output logic [IDX_W-1:0]     step_idx,
  output logic [MAX_STEPS-1:0] step_oh
);

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      step_idx <= '0;
      step_oh  <= MAX_STEPS'(1);
    end else if (park) begin
      step_idx <= '0;
      step_oh  <= '0;
    end else if (resume || (adv && wrap)) begin
      step_idx <= '0;
      step_oh  <= MAX_STEPS'(1);
    end else if (adv) begin
      step_idx <= step_idx + IDX_W'(1);
      step_oh  <= step_oh << 1;
    end
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// MiniSRC multicycle step sequencer: instruction register, fetch/execute walk, halt and pulses.
// Optional stall watchdog enabled by defining CTRL_SEQUENCER_TIMEOUT_EN.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MAX_STEPS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 iClk,
  input  logic                 nRst,
  input  logic                 iRdy,
  input  logic                 iRun,
  input  logic [DATA_W-1:0]    iMemData,
  output logic [DATA_W-1:0]    oIR,
  output logic [4:0]           oOpcode,
  output logic [MAX_STEPS-1:0] oStep,
  output logic                 oFetch,
  output logic                 oIR_en,
  output logic                 oDone,
  output logic                 oIllegal,
  output logic                 oHalted,
  output logic                 oFault
);

  localparam int IDX_W = $clog2(MAX_STEPS);
  localparam logic [IDX_W-1:0] T2_IDX = IDX_W'(FETCH_STEPS - 1);

  seq_state_t              state;
  logic [DATA_W-1:0]       ir;
  logic                    done_q;
  logic                    ill_q;
  logic [IDX_W-1:0]        step_idx;
  logic [MAX_STEPS-1:0]    step_oh;
  logic [OPC_W-1:0]        opcode;
  logic [IDX_W-1:0]        last_idx;
  logic                    active;
  logic                    is_last;
  logic                    timeout_hit;
  logic                    adv;
  logic                    park;
  logic                    resume;

  assign opcode   = ir[DATA_W-1 -: OPC_W];
  assign last_idx = T2_IDX + IDX_W'(exec_steps(opcode));
  assign active   = (state == S_FETCH) || (state == S_EXEC);
  assign is_last  = (state == S_EXEC) && (step_idx == last_idx);
  assign adv      = active && iRdy && !timeout_hit;
  // Halt retires into HALTED instead of wrapping; a timeout abandons the step outright.
  assign park     = (adv && is_last && (opcode == OP_HALT)) || (active && timeout_hit);
  assign resume   = (state == S_HALTED) && iRun;

`ifdef CTRL_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      to_cnt <= '0;
    end else if (active) begin
      if (iRdy)
        to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT))
        to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = active && (to_cnt == TO_W'(TIMEOUT));
  assign oFault      = (state == S_FAULT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign oFault         = 1'b0;
`endif

  ctrl_step_counter #(
    .MAX_STEPS (MAX_STEPS)
  ) u_step (
    .iClk     (iClk),
    .nRst     (nRst),
    .adv      (adv),
    .wrap     (is_last),
    .park     (park),
    .resume   (resume),
    .step_idx (step_idx),
    .step_oh  (step_oh)
  );

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state  <= S_FETCH;
      ir     <= '0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state)
        S_FETCH: begin
          if (timeout_hit) begin
            state <= S_FAULT;
          end else if (adv && (step_idx == T2_IDX)) begin
            ir    <= iMemData;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (timeout_hit) begin
            state <= S_FAULT;
          end else if (adv && is_last) begin
            if (opcode == OP_HALT) begin
              state <= S_HALTED;
            end else begin
              state  <= S_FETCH;
              done_q <= 1'b1;
              ill_q  <= is_illegal(opcode);
            end
          end
        end
        S_HALTED: begin
          if (iRun) begin
            state  <= S_FETCH;
            done_q <= 1'b1;
          end
        end
        default: state <= S_FAULT;
      endcase
    end
  end

  assign oIR      = ir;
  assign oOpcode  = opcode;
  assign oStep    = step_oh;
  assign oFetch   = (state == S_FETCH);
  assign oIR_en   = (state == S_FETCH) && (step_idx == T2_IDX);
  assign oDone    = done_q;
  assign oIllegal = ill_q;
  assign oHalted  = (state == S_HALTED);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: vector table for fetch/execute walks plus hand-written corner sequences.
module tb_ctrl_sequencer;

  localparam int DATA_W    = 32;
  localparam int MAX_STEPS = 8;
  localparam int TIMEOUT   = 4;

  logic                 iClk = 1'b0;
  logic                 nRst;
  logic                 iRdy;
  logic                 iRun;
  logic [DATA_W-1:0]    iMemData;
  logic [DATA_W-1:0]    oIR;
  logic [4:0]           oOpcode;
  logic [MAX_STEPS-1:0] oStep;
  logic                 oFetch;
  logic                 oIR_en;
  logic                 oDone;
  logic                 oIllegal;
  logic                 oHalted;
  logic                 oFault;

  ctrl_sequencer #(
    .DATA_W    (DATA_W),
    .MAX_STEPS (MAX_STEPS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .iClk     (iClk),
    .nRst     (nRst),
    .iRdy     (iRdy),
    .iRun     (iRun),
    .iMemData (iMemData),
    .oIR      (oIR),
    .oOpcode  (oOpcode),
    .oStep    (oStep),
    .oFetch   (oFetch),
    .oIR_en   (oIR_en),
    .oDone    (oDone),
    .oIllegal (oIllegal),
    .oHalted  (oHalted),
    .oFault   (oFault)
  );

  always #5 iClk = ~iClk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rdy;
    logic [4:0] op_in;
    logic [7:0] step;
    logic       fetch;
    logic       iren;
    logic       done;
    logic       ill;
    logic [4:0] op;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk_word(input logic [4:0] op);
    return {op, 27'h0123456};
  endfunction

  task automatic do_reset();
    nRst     = 1'b0;
    iRdy     = 1'b0;
    iRun     = 1'b0;
    iMemData = '0;
    tick();
    tick();
    chk("rst_step",    32'(oStep), 32'h1);
    chk("rst_ir",      oIR, 32'h0);
    chk("rst_fetch",   32'(oFetch), 32'h1);
    chk("rst_iren",    32'(oIR_en), 32'h0);
    chk("rst_done",    32'(oDone), 32'h0);
    chk("rst_illegal", 32'(oIllegal), 32'h0);
    chk("rst_halted",  32'(oHalted), 32'h0);
    chk("rst_fault",   32'(oFault), 32'h0);
    @(negedge iClk);
    nRst = 1'b1;
  endtask

  initial begin
    //          rdy   op_in  step   fet   iren  done  ill   op
    vecs[0]  = '{1'b1, 5'd3,  8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[1]  = '{1'b1, 5'd3,  8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[2]  = '{1'b1, 5'd3,  8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[3]  = '{1'b1, 5'd3,  8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[4]  = '{1'b1, 5'd3,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[5]  = '{1'b1, 5'd3,  8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[6]  = '{1'b1, 5'd0,  8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3};
    vecs[7]  = '{1'b1, 5'd0,  8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3};
    vecs[8]  = '{1'b1, 5'd0,  8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[9]  = '{1'b1, 5'd0,  8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{1'b0, 5'd0,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[11] = '{1'b0, 5'd0,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[12] = '{1'b0, 5'd0,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[13] = '{1'b1, 5'd0,  8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[14] = '{1'b1, 5'd0,  8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[15] = '{1'b1, 5'd0,  8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[16] = '{1'b1, 5'd30, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[17] = '{1'b1, 5'd30, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[18] = '{1'b1, 5'd30, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[19] = '{1'b1, 5'd30, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 5'd30};
    vecs[20] = '{1'b1, 5'd30, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 5'd30};

    // add, ld with a three-cycle stall at T4, then an illegal opcode
    do_reset();
    for (int i = 0; i < 21; i++) begin
      iRdy     = vecs[i].rdy;
      iRun     = 1'b0;
      iMemData = mk_word(vecs[i].op_in);
      #1;
      chk($sformatf("v%0d_step", i),    32'(oStep), 32'(vecs[i].step));
      chk($sformatf("v%0d_fetch", i),   32'(oFetch), 32'(vecs[i].fetch));
      chk($sformatf("v%0d_iren", i),    32'(oIR_en), 32'(vecs[i].iren));
      chk($sformatf("v%0d_done", i),    32'(oDone), 32'(vecs[i].done));
      chk($sformatf("v%0d_illegal", i), 32'(oIllegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d_opcode", i),  32'(oOpcode), 32'(vecs[i].op));
      chk($sformatf("v%0d_halted", i),  32'(oHalted), 32'h0);
      tick();
    end

    // halt, idle in HALTED with iRdy toggling, then an iRun pulse
    do_reset();
    iRdy     = 1'b1;
    iMemData = mk_word(5'd27);
    tick(); tick(); tick();
    chk("halt_t3_step", 32'(oStep), 32'h08);
    tick();
    chk("halt_step",   32'(oStep), 32'h0);
    chk("halt_flag",   32'(oHalted), 32'h1);
    chk("halt_done",   32'(oDone), 32'h0);
    chk("halt_fetch",  32'(oFetch), 32'h0);
    for (int i = 0; i < 5; i++) begin
      iRdy = i[0];
      tick();
      chk($sformatf("halt_hold%0d_step", i), 32'(oStep), 32'h0);
      chk($sformatf("halt_hold%0d_flag", i), 32'(oHalted), 32'h1);
    end
    iRun = 1'b1;
    tick();
    chk("run_step",   32'(oStep), 32'h1);
    chk("run_done",   32'(oDone), 32'h1);
    chk("run_halted", 32'(oHalted), 32'h0);
    iRun = 1'b0;
    iRdy = 1'b1;
    tick();
    chk("run_next_step", 32'(oStep), 32'h2);
    chk("run_next_done", 32'(oDone), 32'h0);

    // IR holds while stalled at T2, then a mul aborted by reset at T4
    do_reset();
    iRdy     = 1'b1;
    iMemData = mk_word(5'd8);
    tick(); tick();
    iRdy     = 1'b0;
    iMemData = mk_word(5'd26);
    tick();
    chk("t2_stall_step", 32'(oStep), 32'h04);
    chk("t2_stall_ir",   oIR, 32'h0);
    iRdy     = 1'b1;
    iMemData = mk_word(5'd15);
    tick();
    chk("mul_ir", oIR, {5'd15, 27'h0123456});
    tick();
    chk("mul_t4_step", 32'(oStep), 32'h10);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_rst_step",  32'(oStep), 32'h1);
    chk("async_rst_ir",    oIR, 32'h0);
    chk("async_rst_fetch", 32'(oFetch), 32'h1);
    @(negedge iClk);
    nRst     = 1'b1;
    iMemData = mk_word(5'd26);
    tick();
    chk("nop_t1", 32'(oStep), 32'h02);
    tick();
    chk("nop_t2", 32'(oStep), 32'h04);
    tick();
    chk("nop_t3", 32'(oStep), 32'h08);
    chk("nop_t3_done", 32'(oDone), 32'h0);
    tick();
    chk("nop_wrap_step", 32'(oStep), 32'h01);
    chk("nop_wrap_done", 32'(oDone), 32'h1);

    // long stall at T1
    do_reset();
    iRdy = 1'b1;
    tick();
    iRdy = 1'b0;
`ifdef CTRL_SEQUENCER_TIMEOUT_EN
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk($sformatf("to_wait%0d_fault", i), 32'(oFault), 32'h0);
      chk($sformatf("to_wait%0d_step", i),  32'(oStep), 32'h02);
    end
    tick();
    chk("to_fault", 32'(oFault), 32'h1);
    chk("to_step",  32'(oStep), 32'h0);
    iRdy = 1'b1;
    iRun = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("to_sticky%0d_fault", i), 32'(oFault), 32'h1);
      chk($sformatf("to_sticky%0d_step", i),  32'(oStep), 32'h0);
    end
    iRun = 1'b0;
    #2;
    nRst = 1'b0;
    #1;
    chk("to_clear_fault", 32'(oFault), 32'h0);
    chk("to_clear_step",  32'(oStep), 32'h1);
    @(negedge iClk);
    nRst = 1'b1;
`else
    for (int i = 0; i < 20; i++) tick();
    chk("stall_step",  32'(oStep), 32'h02);
    chk("stall_fault", 32'(oFault), 32'h0);
    iRdy = 1'b1;
    tick();
    chk("stall_resume_step", 32'(oStep), 32'h04);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
